// File: rtl/calculator_unit.sv
// Sequential 6-bit unsigned arithmetic unit.
// A start request captures both operands. Sum, difference and product are formed immediately. A 6-cycle restoring divider then runs, and all four results are published together with a one-cycle valid strobe.
module calculator_unit (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [5:0]  i_data1,
  input  logic [5:0]  i_data2,
  output logic [6:0]  o_add,
  output logic [6:0]  o_sub,
  output logic [11:0] o_mul,
  output logic [5:0]  o_div,
  output logic        o_busy,
  output logic        o_valid
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ADD_W = OP_W + 1;
  localparam int unsigned MUL_W = 2 * OP_W;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADD_W-1:0]   add_r_q, add_r_d;
  logic [ADD_W-1:0]   sub_r_q, sub_r_d;
  logic [MUL_W-1:0]   mul_r_q, mul_r_d;
  logic [OP_W-1:0]    y_q, y_d;
  logic [OP_W-1:0]    dvd_q, dvd_d;
  logic [OP_W-1:0]    rem_q, rem_d;
  logic [OP_W-1:0]    quo_q, quo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADD_W-1:0]   add_o_q, add_o_d;
  logic [ADD_W-1:0]   sub_o_q, sub_o_d;
  logic [MUL_W-1:0]   mul_o_q, mul_o_d;
  logic [OP_W-1:0]    div_o_q, div_o_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;

  // One restoring step: shift in next dividend bit, trial-subtract divisor
  logic [ADD_W-1:0]   rem_shift;
  logic [ADD_W-1:0]   rem_sub;
  logic               rem_ge;

  assign rem_shift = {rem_q, dvd_q[OP_W-1]};
  assign rem_sub   = rem_shift - {1'b0, y_q};
  assign rem_ge    = (rem_shift >= {1'b0, y_q});

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      add_r_q <= '0;
      sub_r_q <= '0;
      mul_r_q <= '0;
      y_q     <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      add_o_q <= '0;
      sub_o_q <= '0;
      mul_o_q <= '0;
      div_o_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      add_r_q <= add_r_d;
      sub_r_q <= sub_r_d;
      mul_r_q <= mul_r_d;
      y_q     <= y_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      add_o_q <= add_o_d;
      sub_o_q <= sub_o_d;
      mul_o_q <= mul_o_d;
      div_o_q <= div_o_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    add_r_d = add_r_q;
    sub_r_d = sub_r_q;
    mul_r_d = mul_r_q;
    y_d     = y_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    add_o_d = add_o_q;
    sub_o_d = sub_o_q;
    mul_o_d = mul_o_q;
    div_o_d = div_o_q;
    busy_d  = busy_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          add_r_d = ADD_W'(i_data1) + ADD_W'(i_data2);
          sub_r_d = ADD_W'(i_data1) - ADD_W'(i_data2);
          mul_r_d = MUL_W'(i_data1) * MUL_W'(i_data2);
          y_d     = i_data2;
          dvd_d   = i_data1;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CNT_W'(OP_W);
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        // Divide by zero always takes the subtract path, giving an all-ones quotient
        rem_d   = rem_ge ? OP_W'(rem_sub) : OP_W'(rem_shift);
        quo_d   = {quo_q[OP_W-2:0], rem_ge};
        dvd_d   = {dvd_q[OP_W-2:0], 1'b0};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        add_o_d = add_r_q;
        sub_o_d = sub_r_q;
        mul_o_d = mul_r_q;
        div_o_d = quo_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign o_add   = add_o_q;
  assign o_sub   = sub_o_q;
  assign o_mul   = mul_o_q;
  assign o_div   = div_o_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_calculator_unit.sv
// Directed, table-driven bench for calculator_unit.
// It also runs hand-written sequences for reset, a held start request and an abort during division.
module tb_calculator_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  data1;
  logic [5:0]  data2;
  logic [6:0]  o_add;
  logic [6:0]  o_sub;
  logic [11:0] o_mul;
  logic [5:0]  o_div;
  logic        o_busy;
  logic        o_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [6:0]  add;
    logic [6:0]  sub;
    logic [11:0] mul;
    logic [5:0]  div;
  } vec_t;

  vec_t vecs[8];

  logic [6:0]  prev_add;
  logic [6:0]  prev_sub;
  logic [11:0] prev_mul;
  logic [5:0]  prev_div;

  calculator_unit dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_data1 (data1),
    .i_data2 (data2),
    .o_add   (o_add),
    .o_sub   (o_sub),
    .o_mul   (o_mul),
    .o_div   (o_div),
    .o_busy  (o_busy),
    .o_valid (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input int a, input int s,
                             input int m, input int d);
    chk({tag, " add"}, int'(o_add), a);
    chk({tag, " sub"}, int'(o_sub), s);
    chk({tag, " mul"}, int'(o_mul), m);
    chk({tag, " div"}, int'(o_div), d);
  endtask

  // Present a start at a negedge.
  // Return at the negedge right after the accepting edge.
  task automatic start_op(input logic [5:0] x, input logic [5:0] y);
    start = 1'b1;
    data1 = x;
    data2 = y;
    @(negedge clk);
    start = 1'b0;
    data1 = ~x;
    data2 = y ^ 6'h15;
    chk("busy after accept", int'(o_busy), 1);
    chk("valid after accept", int'(o_valid), 0);
    chk_outputs("hold", int'(prev_add), int'(prev_sub), int'(prev_mul), int'(prev_div));
  endtask

  // Count edges after the accepting edge until valid, bounded
  task automatic wait_valid(output int lat, output bit seen);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    seen = o_valid;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL valid timeout: got no valid, expected valid within 20 cycles");
    end
  endtask

  task automatic count_valids(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (o_valid) n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    bit seen;
    start_op(v.x, v.y);
    wait_valid(lat, seen);
    if (seen) begin
      chk("latency", lat, 7);
      chk("busy at valid", int'(o_busy), 0);
      chk_outputs($sformatf("x=%0d y=%0d", v.x, v.y),
                  int'(v.add), int'(v.sub), int'(v.mul), int'(v.div));
    end
    prev_add = v.add;
    prev_sub = v.sub;
    prev_mul = v.mul;
    prev_div = v.div;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   lat;
    int   n;
    bit   seen;
    vec_t v;

    vecs[0] = '{x: 6'd4,  y: 6'd2,  add: 7'd6,   sub: 7'd2,    mul: 12'd8,    div: 6'd2};
    vecs[1] = '{x: 6'd5,  y: 6'd6,  add: 7'd11,  sub: 7'h7F,   mul: 12'd30,   div: 6'd0};
    vecs[2] = '{x: 6'd7,  y: 6'd2,  add: 7'd9,   sub: 7'd5,    mul: 12'd14,   div: 6'd3};
    vecs[3] = '{x: 6'd63, y: 6'd63, add: 7'd126, sub: 7'd0,    mul: 12'd3969, div: 6'd1};
    vecs[4] = '{x: 6'd0,  y: 6'd63, add: 7'd63,  sub: 7'h41,   mul: 12'd0,    div: 6'd0};
    vecs[5] = '{x: 6'd9,  y: 6'd0,  add: 7'd9,   sub: 7'd9,    mul: 12'd0,    div: 6'h3F};
    vecs[6] = '{x: 6'd63, y: 6'd1,  add: 7'd64,  sub: 7'd62,   mul: 12'd63,   div: 6'd63};
    vecs[7] = '{x: 6'd50, y: 6'd7,  add: 7'd57,  sub: 7'd43,   mul: 12'd350,  div: 6'd7};

    prev_add = '0;
    prev_sub = '0;
    prev_mul = '0;
    prev_div = '0;

    // Reset held with start asserted must not launch anything
    rst_n = 1'b0;
    start = 1'b1;
    data1 = 6'd5;
    data2 = 6'd5;
    repeat (2) @(negedge clk);
    chk_outputs("reset", 0, 0, 0, 0);
    chk("reset busy", int'(o_busy), 0);
    chk("reset valid", int'(o_valid), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset busy", int'(o_busy), 0);

    // Consecutive vectors start at the valid negedge: back-to-back throughput
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      run_vec(v);
    end
    @(negedge clk);
    chk("valid one-cycle", int'(o_valid), 0);

    // Start held high with operands churning: only captured operands count
    start = 1'b1;
    data1 = 6'd10;
    data2 = 6'd3;
    @(negedge clk);
    chk("held busy", int'(o_busy), 1);
    lat = 0;
    while (!o_valid && lat < 20) begin
      data1 = 6'($urandom_range(0, 63));
      data2 = 6'($urandom_range(0, 63));
      @(negedge clk);
      lat++;
      if (!o_valid) chk("held busy during op", int'(o_busy), 1);
    end
    start = 1'b0;
    chk("held latency", lat, 7);
    chk_outputs("held", 13, 7, 30, 3);
    count_valids(12, n);
    chk("held extra valids", n, 0);
    prev_add = 7'd13;
    prev_sub = 7'd7;
    prev_mul = 12'd30;
    prev_div = 6'd3;

    // Reset during division aborts with no valid
    start_op(6'd20, 6'd4);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs("abort", 0, 0, 0, 0);
    chk("abort busy", int'(o_busy), 0);
    chk("abort valid", int'(o_valid), 0);
    rst_n = 1'b1;
    count_valids(12, n);
    chk("abort valids", n, 0);
    prev_add = '0;
    prev_sub = '0;
    prev_mul = '0;
    prev_div = '0;
    v = '{x: 6'd20, y: 6'd4, add: 7'd24, sub: 7'd16, mul: 12'd80, div: 6'd5};
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
